div_unit: RTL

- Iterative multi-cycle divider that responds to the ALU-side validIn/validOut handshake for DIV/DIVU.
- Accepts a request, computes the 32-bit quotient and remainder at one restoring step per cycle, and returns Hi=remainder, Lo=quotient with a one-cycle validOut pulse.
- Sits beside the multiplier under the execute-stage ALU wrapper. The wrapper holds stall high until validOut is seen.

---
 rtl/div_unit_if.sv | 26 ++
 rtl/div_unit.sv | 130 +++++++++++++
 2 files changed

// File: rtl/div_unit_if.sv
// Request/result bundle between the execute-stage ALU wrapper and the divider.
interface div_unit_if #(
   parameter int unsigned WIDTH = 32
);
   logic             validIn;
   logic             sign;
   logic [WIDTH-1:0] SrcA;
   logic [WIDTH-1:0] SrcB;
   logic             validOut;
   logic [WIDTH-1:0] Hi;
   logic [WIDTH-1:0] Lo;
   logic             busy;
   logic             div_by_zero;

   // Requester side (ALU wrapper)
   modport master (
      output validIn, sign, SrcA, SrcB,
      input  validOut, Hi, Lo, busy, div_by_zero
   );

   // Divider side
   modport slave (
      input  validIn, sign, SrcA, SrcB,
      output validOut, Hi, Lo, busy, div_by_zero
   );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle,
// fixed WIDTH+1 edges from acceptance to the registered result.
// Hi = remainder, Lo = quotient; signed results truncate toward zero and the
// remainder follows the dividend's sign.
module div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input logic       clk,
   input logic       reset_n,
   div_unit_if.slave bus
);

   localparam int unsigned CntW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StFinish
   } state_e;

   state_e           r_state;
   logic [CntW-1:0]  r_cnt;
   logic [WIDTH-1:0] r_rem;      // partial remainder
   logic [WIDTH-1:0] r_dvd;      // dividend bits shifting out, quotient bits shifting in
   logic [WIDTH-1:0] r_dvs;      // divisor magnitude
   logic [WIDTH-1:0] r_srca;     // original dividend, returned as Hi on divide by zero
   logic             r_qneg;
   logic             r_rneg;
   logic             r_valid_out;
   logic             r_busy;
   logic             r_dbz;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;

   logic             w_a_neg;
   logic             w_b_neg;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_diff;
   logic             w_ge;
   logic             w_dbz;
   logic [WIDTH-1:0] w_q_fix;
   logic [WIDTH-1:0] w_r_fix;

   // Operand magnitudes; raw values pass through for unsigned requests
   always_comb begin
      w_a_neg = bus.sign & bus.SrcA[WIDTH-1];
      w_b_neg = bus.sign & bus.SrcB[WIDTH-1];
      w_a_mag = w_a_neg ? ({WIDTH{1'b0}} - bus.SrcA) : bus.SrcA;
      w_b_mag = w_b_neg ? ({WIDTH{1'b0}} - bus.SrcB) : bus.SrcB;
   end

   // One restoring step: the borrow out of the (WIDTH+1)-bit subtract decides the quotient bit.
   // A zero divisor always "fits"; its quotient is overridden at FINISH anyway.
   always_comb begin
      w_shift = {r_rem, r_dvd[WIDTH-1]};
      w_diff  = w_shift - {1'b0, r_dvs};
      w_dbz   = (r_dvs == '0);
      w_ge    = w_dbz | ~w_diff[WIDTH];
   end

   // Sign correction of the finished magnitudes
   always_comb begin
      w_q_fix = r_qneg ? ({WIDTH{1'b0}} - r_dvd) : r_dvd;
      w_r_fix = r_rneg ? ({WIDTH{1'b0}} - r_rem) : r_rem;
   end

   // Control FSM with datapath and registered outputs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= StIdle;
         r_cnt       <= '0;
         r_rem       <= '0;
         r_dvd       <= '0;
         r_dvs       <= '0;
         r_srca      <= '0;
         r_qneg      <= 1'b0;
         r_rneg      <= 1'b0;
         r_valid_out <= 1'b0;
         r_busy      <= 1'b0;
         r_dbz       <= 1'b0;
         r_hi        <= '0;
         r_lo        <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               r_valid_out <= 1'b0;
               if (bus.validIn) begin
                  r_dvd   <= w_a_mag;
                  r_dvs   <= w_b_mag;
                  r_srca  <= bus.SrcA;
                  r_qneg  <= w_a_neg ^ w_b_neg;
                  r_rneg  <= w_a_neg;
                  r_rem   <= '0;
                  r_cnt   <= CntW'(WIDTH);
                  r_busy  <= 1'b1;
                  r_state <= StBusy;
               end
            end
            StBusy: begin
               r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
               r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == CntW'(1)) begin
                  r_state <= StFinish;
               end
            end
            StFinish: begin
               r_lo        <= w_dbz ? {WIDTH{1'b1}} : w_q_fix;
               r_hi        <= w_dbz ? r_srca : w_r_fix;
               r_dbz       <= w_dbz;
               r_valid_out <= 1'b1;
               r_busy      <= 1'b0;
               r_state     <= StIdle;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign bus.validOut    = r_valid_out;
   assign bus.Hi          = r_hi;
   assign bus.Lo          = r_lo;
   assign bus.busy        = r_busy;
   assign bus.div_by_zero = r_dbz;

endmodule
